// File: rtl/zca_pkg.sv
// Shared definitions for the time-shared zero-count engine: FSM encoding,
// default sizes and the width-derivation helpers used by every module.
package zca_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } zca_state_e;

  localparam int ZCA_DEF_N_REQ  = 4;
  localparam int ZCA_DEF_DATA_W = 8;

  // Requester index width; a single-bit index is kept even for degenerate sizes.
  function automatic int zca_id_w(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

  // Result width must hold DATA_W itself (the all-zeros word).
  function automatic int zca_cnt_w(input int data_w);
    return $clog2(data_w + 1);
  endfunction

  function automatic int zca_idx_w(input int data_w);
    return (data_w > 1) ? $clog2(data_w) : 1;
  endfunction

endpackage

// File: rtl/zcount_serial.sv
// Serial zero counter: a shift register examined LSB first, one bit per
// enabled clock, with a bit index and a running zero accumulator.
module zcount_serial
  import zca_pkg::*;
#(
  parameter  int DATA_W = ZCA_DEF_DATA_W,
  localparam int CNT_W  = zca_cnt_w(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              en,
  input  logic [DATA_W-1:0] data_in,
  output logic              last_bit,
  output logic [CNT_W-1:0]  zero_cnt_next
);

  localparam int IDX_W = zca_idx_w(DATA_W);

  logic [DATA_W-1:0] sr_q, sr_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0]  zero_cnt_q, zero_cnt_d;

  // The next count already includes the bit under examination, so the
  // owner can capture the final total on the same edge as the last bit.
  assign zero_cnt_next = zero_cnt_q + CNT_W'(~sr_q[0]);
  assign last_bit      = (bit_idx_q == IDX_W'(DATA_W - 1));

  always_comb begin
    sr_d       = sr_q;
    bit_idx_d  = bit_idx_q;
    zero_cnt_d = zero_cnt_q;
    if (load) begin
      sr_d       = data_in;
      bit_idx_d  = '0;
      zero_cnt_d = '0;
    end else if (en) begin
      sr_d       = sr_q >> 1;
      bit_idx_d  = bit_idx_q + IDX_W'(1);
      zero_cnt_d = zero_cnt_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q       <= '0;
      bit_idx_q  <= '0;
      zero_cnt_q <= '0;
    end else begin
      sr_q       <= sr_d;
      bit_idx_q  <= bit_idx_d;
      zero_cnt_q <= zero_cnt_d;
    end
  end

endmodule

// File: rtl/zcount_arbiter.sv
// Arbitrated, time-shared zero counter. Fixed priority (lowest index) by
// default; define ZCA_ROUND_ROBIN_EN for round-robin arbitration.
module zcount_arbiter
  import zca_pkg::*;
#(
  parameter  int N_REQ  = ZCA_DEF_N_REQ,
  parameter  int DATA_W = ZCA_DEF_DATA_W,
  localparam int ID_W   = zca_id_w(N_REQ),
  localparam int CNT_W  = zca_cnt_w(DATA_W)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        gnt,
  output logic                    busy,
  output logic                    done_valid,
  output logic [ID_W-1:0]         done_id,
  output logic [CNT_W-1:0]        done_count
);

  zca_state_e        state_q, state_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic              busy_q, busy_d;
  logic              done_valid_q, done_valid_d;
  logic [ID_W-1:0]   done_id_q, done_id_d;
  logic [CNT_W-1:0]  done_count_q, done_count_d;

  logic              win_found;
  logic [ID_W-1:0]   win_idx;
  logic [DATA_W-1:0] sel_data;
  logic              load;
  logic              en;
  logic              last_bit;
  logic [CNT_W-1:0]  zero_cnt_next;

`ifdef ZCA_ROUND_ROBIN_EN
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   cand;

  // Search begins one past the last winner so every requester gets a turn.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = ID_W'((int'(rr_ptr_q) + 1 + i) % N_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end
`else
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_found = 1'b1;
        win_idx   = ID_W'(i);
      end
    end
  end
`endif

  assign sel_data = req_data[int'(win_idx)*DATA_W +: DATA_W];

  always_comb begin
    state_d      = state_q;
    gnt_d        = '0;
    done_valid_d = 1'b0;
    done_id_d    = done_id_q;
    done_count_d = done_count_q;
    load         = 1'b0;
    en           = 1'b0;
`ifdef ZCA_ROUND_ROBIN_EN
    rr_ptr_d     = rr_ptr_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          load      = 1'b1;
          state_d   = ST_COUNT;
          gnt_d     = N_REQ'(1) << win_idx;
          done_id_d = win_idx;
`ifdef ZCA_ROUND_ROBIN_EN
          rr_ptr_d  = win_idx;
`endif
        end
      end
      ST_COUNT: begin
        en = 1'b1;
        if (last_bit) begin
          state_d      = ST_DONE;
          done_valid_d = 1'b1;
          done_count_d = zero_cnt_next;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      gnt_q        <= '0;
      busy_q       <= 1'b0;
      done_valid_q <= 1'b0;
      done_id_q    <= '0;
      done_count_q <= '0;
`ifdef ZCA_ROUND_ROBIN_EN
      rr_ptr_q     <= ID_W'(N_REQ - 1);
`endif
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      busy_q       <= busy_d;
      done_valid_q <= done_valid_d;
      done_id_q    <= done_id_d;
      done_count_q <= done_count_d;
`ifdef ZCA_ROUND_ROBIN_EN
      rr_ptr_q     <= rr_ptr_d;
`endif
    end
  end

  zcount_serial #(
    .DATA_W (DATA_W)
  ) u_serial (
    .clk           (clk),
    .rst_n         (rst_n),
    .load          (load),
    .en            (en),
    .data_in       (sel_data),
    .last_bit      (last_bit),
    .zero_cnt_next (zero_cnt_next)
  );

  assign gnt        = gnt_q;
  assign busy       = busy_q;
  assign done_valid = done_valid_q;
  assign done_id    = done_id_q;
  assign done_count = done_count_q;

endmodule

// File: doc/zcount_arbiter.md
# zcount_arbiter

Sequential zero-count engine shared between several requesters. Each requester presents a data word; the block arbitrates, latches the winner's word, counts its zero bits serially (one bit per clock), then returns the count tagged with the requester index. It sits between the byte producers and the consumers of the zero-count result, and replaces per-requester combinational counters with one time-shared unit.

## Interface
- `N_REQ`, default 4: number of requesters, ≥2.
- `DATA_W`, default 8: data word width, ≥2.
- `ID_W`, derived: `$clog2(N_REQ)`.
- `CNT_W`, derived: `$clog2(DATA_W+1)`.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  N_REQ  per-requester request level.
- `req_data`  in  N_REQ*DATA_W  packed words; requester i occupies `[i*DATA_W +: DATA_W]`.
- `gnt`  out  N_REQ  one-hot, registered, high for exactly one cycle when a word is accepted.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done_valid`  out  1  one-cycle result strobe.
- `done_id`  out  ID_W  index of the requester whose result is presented.
- `done_count`  out  CNT_W  number of zero bits in the accepted word.

## Operation
- FSM states: IDLE, COUNT, DONE.
- IDLE: at the rising edge where `req` ≠ 0, select the winner, latch its word into the shift register, clear the bit counter and the zero counter, load `gnt` with the one-hot winner and `done_id` with its index, and go to COUNT. If `req` = 0, stay in IDLE.
- COUNT: on each edge, examine latched bit `bit_idx` (LSB first); if it is 0, increment the zero counter. After `DATA_W` edges, go to DONE.
- DONE: `done_valid` = 1. `done_count` holds the final count. On the next edge, go to IDLE.
- Requesters hold `req` and `req_data` stable until they see their `gnt`, then drop or re-assert `req`. `req` is ignored outside IDLE. Words are never queued.
- `done_count` and `done_id` hold their last values until the next DONE. They are valid only while `done_valid` is high.
- Count arithmetic: unsigned, `CNT_W` bits, cannot overflow (maximum `DATA_W`). All-ones input gives 0. All-zeros input gives `DATA_W`.
- Reset, including mid-COUNT: state goes to IDLE and all outputs to 0, including `gnt`, `busy`, `done_valid`, `done_id` and `done_count`. The round-robin pointer resets to N_REQ-1. The in-flight job is dropped and no DONE is emitted.

## Timing
- Acceptance edge E0 → `gnt` high during cycle E0..E1, and `busy` high from E0.
- Bits are processed at edges E1..E_DATA_W. `done_valid` is high during the cycle after E_DATA_W.
- IDLE is re-entered at E_DATA_W+1. The earliest next acceptance is at E_DATA_W+2.
- Throughput: one word per DATA_W+2 cycles (10 cycles for DATA_W=8).
- Results appear in acceptance order. Exactly one result is produced per grant.

## Configuration
- `ZCA_ROUND_ROBIN_EN` defined: round-robin arbitration. The search starts at (last granted index + 1) mod N_REQ. The pointer updates only on a grant.
- Not defined: fixed priority, where the lowest asserted index wins. The pointer logic is not present.

## Structure
- `zca_pkg`: state encoding (IDLE/COUNT/DONE) and width helper constants/functions (`ID_W`, `CNT_W` derivation).
- Sub-module `zcount_serial`: holds the shift register, `bit_idx` counter and zero accumulator. It has a load/enable interface and a `last_bit` flag. The arbiter/FSM stays in the top module.

## Test plan
- Single requester 0, word 8'b00101101 → `gnt`=4'b0001 for one cycle; 8 cycles later `done_valid` with `done_id`=0 and `done_count`=4.
- Edge words 8'hFF and 8'h00 on requester 2 → `done_count`=0 and 8 respectively, with `done_id`=2.
- All four requesters held continuously, round-robin enabled → grants in order 0,1,2,3,0, spaced 10 cycles apart. Without the macro, requester 0 is granted every time.
- Requester 3 asserts `req` during COUNT → no `gnt` until the IDLE cycle after DONE, and the in-flight result is not disturbed.
- `rst_n` pulled low at the 4th COUNT cycle → all outputs are 0 immediately and no `done_valid` follows. A fresh request after release is granted to index 0 first.
- Random words and random `req` patterns, checked against a reference popcount of `~data` → every grant yields exactly one matching result.
